// File: rtl/flag_branch_unit.sv
// flag_branch_unit
//   Consumer of the execute stage's {valid, C, N, Z} status. Holds the
//   architectural condition-code register (CCR), resolves conditional jumps
//   against it (with a same-cycle bypass of the flags being written), and
//   saves/restores the CCR around interrupts.
//
// Parameters
//   CONSUME_EN  1: a taken conditional jump clears the flag it tested.
//   PEND_EN     1: int_req arriving while busy (or while stalled) is latched.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   stall                freezes CCR, shadow, FSM and branch evaluation
//   flag_we, new_status  flag update {valid, C, N, Z}; needs valid=1
//   flag_mask            per-flag update enable {C, N, Z}
//   setc, clrc           force C high / low (setc wins)
//   jmp_valid, jmp_cond  jump request; 00 JZ, 01 JN, 10 JC, 11 JMP
//   int_req, rti         interrupt request / return-from-interrupt pulses
//   ccr                  current {C, N, Z}
//   branch_taken, flush  registered jump-taken indication (flush is 0 after stall)
//   int_ack              high for the single SAVE cycle
//   int_busy             high in SAVE and ACTIVE
//   int_pending          a deferred interrupt request is latched
module flag_branch_unit #(
  parameter bit CONSUME_EN = 1'b1,
  parameter bit PEND_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       flag_we,
  input  logic [3:0] new_status,
  input  logic [2:0] flag_mask,
  input  logic       setc,
  input  logic       clrc,
  input  logic       jmp_valid,
  input  logic [1:0] jmp_cond,
  input  logic       int_req,
  input  logic       rti,
  output logic [2:0] ccr,
  output logic       branch_taken,
  output logic       flush,
  output logic       int_ack,
  output logic       int_busy,
  output logic       int_pending
);

  typedef enum logic [1:0] {IDLE, SAVE, ACTIVE} state_t;
  typedef enum logic [1:0] {COND_JZ, COND_JN, COND_JC, COND_JMP} cond_t;

  localparam int unsigned FZ = 0;
  localparam int unsigned FN = 1;
  localparam int unsigned FC = 2;

  state_t     state;
  cond_t      cond;
  logic [2:0] shadow;
  logic [2:0] fwd;
  logic [2:0] consumed;
  logic [2:0] ccr_nxt;
  logic       hit;
  logic       taken;
  logic       restore;

  assign cond = cond_t'(jmp_cond);

  // Flags as they will be after this cycle's execute result, so a jump in
  // the same cycle sees them without waiting for the CCR write.
  always_comb begin
    fwd = ccr;
    if (flag_we && new_status[3]) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (flag_mask[i]) fwd[i] = new_status[i];
      end
    end
    if (setc)      fwd[FC] = 1'b1;
    else if (clrc) fwd[FC] = 1'b0;
  end

  always_comb begin
    hit = 1'b0;
    unique case (cond)
      COND_JZ:  hit = fwd[FZ];
      COND_JN:  hit = fwd[FN];
      COND_JC:  hit = fwd[FC];
      COND_JMP: hit = 1'b1;
      default:  hit = 1'b0;
    endcase
    taken = jmp_valid && hit;
  end

  always_comb begin
    consumed = fwd;
    if (CONSUME_EN && taken) begin
      unique case (cond)
        COND_JZ:  consumed[FZ] = 1'b0;
        COND_JN:  consumed[FN] = 1'b0;
        COND_JC:  consumed[FC] = 1'b0;
        default:  consumed = fwd;
      endcase
    end
    // A restore overrides everything presented in the same cycle.
    restore = (state == ACTIVE) && rti;
    ccr_nxt = restore ? shadow : consumed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr          <= '0;
      shadow       <= '0;
      state        <= IDLE;
      branch_taken <= 1'b0;
      flush        <= 1'b0;
      int_ack      <= 1'b0;
      int_busy     <= 1'b0;
      int_pending  <= 1'b0;
    end else if (stall) begin
      // Everything holds except flush, which must not redirect fetch twice.
      // A request during a stall cannot start SAVE, so it is parked.
      flush <= 1'b0;
      if (PEND_EN && int_req) int_pending <= 1'b1;
    end else begin
      ccr          <= ccr_nxt;
      branch_taken <= taken;
      flush        <= taken;
      unique case (state)
        IDLE: begin
          if (int_req || int_pending) begin
            state       <= SAVE;
            int_pending <= 1'b0;
            int_ack     <= 1'b1;
            int_busy    <= 1'b1;
          end
        end
        SAVE: begin
          // Capture the post-update value so a flag write in this cycle
          // is part of the saved context.
          shadow  <= ccr_nxt;
          state   <= ACTIVE;
          int_ack <= 1'b0;
          if (PEND_EN && int_req) int_pending <= 1'b1;
        end
        ACTIVE: begin
          if (PEND_EN && int_req) int_pending <= 1'b1;
          if (rti) begin
            state    <= IDLE;
            int_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          int_ack  <= 1'b0;
          int_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit. Two instances share stimulus: dut (defaults)
// and dut_nc (CONSUME_EN=0, PEND_EN=0). Expected output vectors are pushed
// to a scoreboard queue as each stimulus row is driven and popped after the
// clock edge.
// Stimulus row : {stall, flag_we, new_status[3:0], flag_mask[2:0],
//                 setc, clrc, jmp_valid, jmp_cond[1:0], int_req, rti}
// Observed row : {nc_ccr[2:0], ccr[2:0], branch_taken, flush,
//                 int_ack, int_busy, int_pending}
module tb_flag_branch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, flag_we, setc, clrc, jmp_valid, int_req, rti;
  logic [3:0] new_status;
  logic [2:0] flag_mask;
  logic [1:0] jmp_cond;
  logic [2:0] ccr, nc_ccr;
  logic       branch_taken, flush, int_ack, int_busy, int_pending;
  logic       nc_branch_taken, nc_flush, nc_int_ack, nc_int_busy, nc_int_pending;
  logic [10:0] obs;
  logic [10:0] sbq[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_branch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flag_we(flag_we),
    .new_status(new_status), .flag_mask(flag_mask), .setc(setc), .clrc(clrc),
    .jmp_valid(jmp_valid), .jmp_cond(jmp_cond), .int_req(int_req), .rti(rti),
    .ccr(ccr), .branch_taken(branch_taken), .flush(flush),
    .int_ack(int_ack), .int_busy(int_busy), .int_pending(int_pending)
  );

  flag_branch_unit #(.CONSUME_EN(1'b0), .PEND_EN(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flag_we(flag_we),
    .new_status(new_status), .flag_mask(flag_mask), .setc(setc), .clrc(clrc),
    .jmp_valid(jmp_valid), .jmp_cond(jmp_cond), .int_req(int_req), .rti(rti),
    .ccr(nc_ccr), .branch_taken(nc_branch_taken), .flush(nc_flush),
    .int_ack(nc_int_ack), .int_busy(nc_int_busy), .int_pending(nc_int_pending)
  );

  always_comb obs = {nc_ccr, ccr, branch_taken, flush, int_ack, int_busy, int_pending};

  task automatic drive(input logic [15:0] s);
    {stall, flag_we, new_status, flag_mask, setc, clrc, jmp_valid, jmp_cond, int_req, rti} = s;
  endtask

  task automatic apply_reset();
    drive('0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    rst_n = 1'b0;
    drive(16'b0_1_1111_111_1_0_1_11_1_0);
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(11'b0);
      @(posedge clk); #1;
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %b required %b", i, obs, e);
      end
    end
    drive('0);
    rst_n = 1'b1;
  endtask

  task automatic test_flag_update();
    logic [15:0] stim [5] = '{
      16'b0_1_1010_111_0_0_0_00_0_0,
      16'b0_0_0000_000_0_0_0_00_0_0,
      16'b0_1_0111_111_0_0_0_00_0_0,   // valid=0: no update
      16'b0_1_1101_001_0_0_0_00_0_0,   // only Z written
      16'b0_1_1100_100_0_0_0_00_0_0};  // only C written
    logic [10:0] expv [5] = '{
      11'b010_010_0_0_0_0_0,
      11'b010_010_0_0_0_0_0,
      11'b010_010_0_0_0_0_0,
      11'b011_011_0_0_0_0_0,
      11'b111_111_0_0_0_0_0};
    logic [10:0] e;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(stim[i]); sbq.push_back(expv[i]);
      @(posedge clk); #1;
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL flag_update[%0d]: got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] stim [8] = '{
      16'b0_1_1001_111_0_0_0_00_0_0,   // ccr=001
      16'b0_0_0000_000_0_0_1_00_0_0,   // JZ taken
      16'b0_0_0000_000_0_0_0_00_0_0,
      16'b0_0_0000_000_0_0_1_00_0_0,   // JZ, Z consumed in dut only
      16'b0_0_0000_000_0_0_1_11_0_0,   // JMP
      16'b0_0_0000_000_0_0_1_01_0_0,   // JN not taken
      16'b0_0_0000_000_1_0_1_10_0_0,   // setc + JC
      16'b0_0_0000_000_1_1_1_10_0_0};  // setc wins over clrc
    logic [10:0] expv [8] = '{
      11'b001_001_0_0_0_0_0,
      11'b001_000_1_1_0_0_0,
      11'b001_000_0_0_0_0_0,
      11'b001_000_0_0_0_0_0,
      11'b001_000_1_1_0_0_0,
      11'b001_000_0_0_0_0_0,
      11'b101_000_1_1_0_0_0,
      11'b101_000_1_1_0_0_0};
    logic [10:0] e;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(stim[i]); sbq.push_back(expv[i]);
      @(posedge clk); #1;
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL branch[%0d]: got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_bypass();
    logic [15:0] stim [3] = '{
      16'b0_1_1001_001_0_0_1_00_0_0,   // write Z and JZ together
      16'b0_0_0000_000_0_0_0_00_0_0,
      16'b0_1_1010_001_0_0_1_01_0_0};  // N masked off: JN not taken
    logic [10:0] expv [3] = '{
      11'b001_000_1_1_0_0_0,
      11'b001_000_0_0_0_0_0,
      11'b000_000_0_0_0_0_0};
    logic [10:0] e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(stim[i]); sbq.push_back(expv[i]);
      @(posedge clk); #1;
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL bypass[%0d]: got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_interrupt();
    logic [15:0] stim [10] = '{
      16'b0_1_1101_111_0_0_0_00_0_0,   // ccr=101
      16'b0_0_0000_000_0_0_0_00_1_0,   // int_req
      16'b0_0_0000_000_0_0_0_00_0_0,   // SAVE, shadow=101
      16'b0_1_1010_111_0_0_0_00_0_0,   // flags 010 in ACTIVE
      16'b0_0_0000_000_0_0_0_00_1_0,   // pending
      16'b0_0_0000_000_0_0_0_00_0_1,   // rti restore
      16'b0_0_0000_000_0_0_0_00_0_0,   // IDLE -> SAVE from pending
      16'b0_0_0000_000_0_0_0_00_0_0,
      16'b0_1_1000_111_0_0_0_00_0_0,
      16'b0_0_0000_000_0_0_0_00_0_1};
    logic [10:0] expv [10] = '{
      11'b101_101_0_0_0_0_0,
      11'b101_101_0_0_1_1_0,
      11'b101_101_0_0_0_1_0,
      11'b010_010_0_0_0_1_0,
      11'b010_010_0_0_0_1_1,
      11'b101_101_0_0_0_0_1,
      11'b101_101_0_0_1_1_0,
      11'b101_101_0_0_0_1_0,
      11'b000_000_0_0_0_1_0,
      11'b000_101_0_0_0_0_0};
    logic [10:0] e;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(stim[i]); sbq.push_back(expv[i]);
      @(posedge clk); #1;
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL interrupt[%0d]: got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stim [6] = '{
      16'b0_1_1100_111_0_0_0_00_1_0,   // ccr=100, int_req
      16'b0_1_1011_111_0_0_0_00_0_0,   // SAVE captures 011
      16'b0_1_1100_111_0_0_0_00_1_1,   // int_req+rti, update discarded
      16'b0_1_1001_111_0_0_0_00_0_1,   // rti in IDLE ignored
      16'b0_1_1110_111_0_0_0_00_0_1,   // rti in SAVE ignored, shadow 110
      16'b0_1_1001_111_0_0_0_00_0_1};  // restore 110
    logic [10:0] expv [6] = '{
      11'b100_100_0_0_1_1_0,
      11'b011_011_0_0_0_1_0,
      11'b011_011_0_0_0_0_1,
      11'b001_001_0_0_1_1_0,
      11'b110_110_0_0_0_1_0,
      11'b001_110_0_0_0_0_0};
    logic [10:0] e;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]); sbq.push_back(expv[i]);
      @(posedge clk); #1;
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] stim [9] = '{
      16'b0_1_1101_111_0_0_0_00_0_0,   // ccr=101
      16'b0_0_0000_000_0_0_1_10_0_0,   // JC taken, C consumed
      16'b1_1_1010_111_0_0_1_10_0_0,   // stalled: hold, flush 0
      16'b1_0_0000_000_0_0_0_00_1_0,   // stalled int_req -> pending
      16'b0_0_0000_000_1_1_0_00_0_0,   // setc+clrc -> C=1, SAVE
      16'b0_0_0000_000_0_0_0_00_0_0,
      16'b0_0_0000_000_0_1_0_00_0_0,   // clrc
      16'b0_0_0000_000_0_0_0_00_0_1,   // restore 101
      16'b0_0_0000_000_0_0_0_00_0_1};  // rti in IDLE ignored
    logic [10:0] expv [9] = '{
      11'b101_101_0_0_0_0_0,
      11'b101_001_1_1_0_0_0,
      11'b101_001_1_0_0_0_0,
      11'b101_001_1_0_0_0_1,
      11'b101_101_0_0_1_1_0,
      11'b101_101_0_0_0_1_0,
      11'b001_001_0_0_0_1_0,
      11'b001_101_0_0_0_0_0,
      11'b001_101_0_0_0_0_0};
    logic [10:0] e;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(stim[i]); sbq.push_back(expv[i]);
      @(posedge clk); #1;
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stall[%0d]: got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] stim [3] = '{
      16'b0_1_1111_111_0_0_0_00_1_0,
      16'b0_0_0000_000_0_0_0_00_0_0,
      16'b0_0_0000_000_0_0_0_00_1_0};
    logic [10:0] expv [3] = '{
      11'b111_111_0_0_1_1_0,
      11'b111_111_0_0_0_1_0,
      11'b111_111_0_0_0_1_1};
    logic [10:0] e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(stim[i]); sbq.push_back(expv[i]);
      @(posedge clk); #1;
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL async_reset_setup[%0d]: got %b required %b", i, obs, e);
      end
    end
    drive('0);
    #3 rst_n = 1'b0;
    sbq.push_back(11'b0);
    #1;
    e = sbq.pop_front(); checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b required %b", obs, e);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(11'b0);
      @(posedge clk); #1;
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL async_reset_after[%0d]: got %b required %b", i, obs, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    drive('0);
    test_reset();
    test_flag_update();
    test_branch();
    test_bypass();
    test_interrupt();
    test_back_to_back();
    test_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer end of the execute stage's 4-bit status output {valid, C, N, Z}.
- Owns the architectural condition-code register (CCR) and resolves conditional jumps against it.
- Saves the CCR on interrupt entry and restores it on RTI.
- Sits between execute (flag producer) and fetch/decode (flush/redirect consumer).

Parameters:
- CONSUME_EN, 1, 1: a taken conditional jump clears the flag it tested; 0: flags untouched by jumps.
- PEND_EN, 1, 1: an int_req arriving while an interrupt is active is latched as pending; 0: it is dropped.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline hold; freezes CCR, FSM and branch evaluation.
- flag_we  in  1  execute result updates flags this cycle.
- new_status  in  4  execute flags: [3] valid, [2] C, [1] N, [0] Z; used only when flag_we=1 and [3]=1.
- flag_mask  in  3  per-flag update enable {C,N,Z}; 0 keeps the old flag.
- setc  in  1  force C=1.
- clrc  in  1  force C=0.
- jmp_valid  in  1  decode presents a jump.
- jmp_cond  in  2  00 JZ, 01 JN, 10 JC, 11 JMP (unconditional).
- int_req  in  1  interrupt request, 1-cycle pulse.
- rti  in  1  return-from-interrupt, 1-cycle pulse.
- ccr  out  3  current {C,N,Z}.
- branch_taken  out  1  registered; jump taken, one cycle after jmp_valid.
- flush  out  1  registered; equals branch_taken.
- int_ack  out  1  1-cycle pulse while in SAVE.
- int_busy  out  1  high in SAVE and ACTIVE.
- int_pending  out  1  pending interrupt latched.

Behaviour:
- Reset (async, rst_n=0): ccr=000, shadow=000, state=IDLE, pending=0. All outputs 0. Reset mid-interrupt discards shadow and pending.
- Forwarded flags fwd, combinational:
  - start from ccr;
  - if flag_we & new_status[3], replace each masked bit with new_status;
  - then setc sets C, or clrc clears C; setc wins if both are high.
- Branch evaluation uses fwd (same-cycle bypass).
  - taken = jmp_valid & (JMP | JZ&fwd.Z | JN&fwd.N | JC&fwd.C).
  - branch_taken/flush register taken; latency 1 cycle; clear to 0 on the next non-taken cycle.
- CCR next value when stall=0, highest priority first:
  1. state=ACTIVE & rti: ccr <= shadow. Same-cycle flag_we/setc/clrc/consume are discarded.
  2. Otherwise ccr <= fwd, with the tested flag cleared if CONSUME_EN & taken & cond≠JMP.
- stall=1: ccr, shadow, state and branch_taken hold; flush forced 0. int_req still sets pending, if PEND_EN.
- Interrupt FSM:
  - IDLE: int_req or pending → SAVE; pending cleared.
  - SAVE (1 cycle): shadow <= next ccr value, so an update in that same cycle is captured; int_ack=1; → ACTIVE.
  - ACTIVE: rti → IDLE with restore; int_req sets pending if PEND_EN.
  - rti in IDLE or SAVE: ignored, no restore.
- Simultaneous int_req and rti in ACTIVE: restore happens, pending set, SAVE on the following cycle (IDLE lasts exactly 1 cycle).
- Flag width is 3 bits; new_status[3]=0 with flag_we=1 performs no update.

Test Plan:
- Reset, then flag_we=1, new_status=1_0_1_0, mask=111 → next cycle ccr=010 (N=1); branch_taken=0.
- ccr=001, jmp_valid with JZ → branch_taken=flush=1 one cycle later; ccr=000. Repeat with CONSUME_EN=0 → ccr stays 001.
- Same-cycle bypass: ccr=000, flag_we sets Z (mask=001), JZ presented in that cycle → taken=1; ccr=000 after consume.
- ccr=101, int_req → SAVE with int_ack=1, shadow=101. Then flags change to 010; int_req during ACTIVE → int_pending=1. rti → ccr=101, IDLE for 1 cycle, then SAVE again with int_ack=1.
- Stall=1 with flag_we and JC valid → ccr unchanged, flush=0; setc & clrc together → C=1; rti in IDLE → ccr unchanged.
- Assert rst_n=0 asynchronously during ACTIVE with pending=1 → all outputs 0 immediately, state IDLE after release.
